// File: rtl/sd_spi_cmd_engine.sv
// rtl/sd_spi_cmd_engine.sv - SD SPI-mode command/response engine with optional R3/R7 tail and block read
module sd_spi_cmd_engine #(
    parameter int CLK_DIV    = 2,
    parameter int NCR_MAX    = 8,
    parameter int TOKEN_MAX  = 4096,
    parameter int DATA_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        resp_ext,
    input  logic        read_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic [7:0]  r1,
    output logic [31:0] resp_word,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [15:0] data_crc,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_R1, EXT, TOKEN, DATA, CRC, TAIL} state_t;

    state_t        state;
    state_t        after_r1;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    idx;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic [7:0]    ncr_cnt;
    logic [15:0]   tok_cnt;
    logic [12:0]   dat_cnt;
    logic [31:0]   arg_l;
    logic [6:0]    crc_l;
    logic          ext_l;
    logic          read_l;
    logic          half_end;
    logic          byte_end;
    logic [7:0]    send_next;
    logic [7:0]    next_tx;
    logic [7:0]    r1_val;
    logic          data_ok;

    // r1_val is the R1 just received in WAIT_R1, or the stored one once EXT finishes
    always_comb begin
        half_end = (div_cnt == DW'(CLK_DIV - 1));
        byte_end = half_end && sclk && (bit_cnt == 3'd7);
        case (idx)
            3'd0:    send_next = arg_l[31:24];
            3'd1:    send_next = arg_l[23:16];
            3'd2:    send_next = arg_l[15:8];
            3'd3:    send_next = arg_l[7:0];
            3'd4:    send_next = {crc_l, 1'b1};
            default: send_next = 8'hFF;
        endcase
        next_tx  = (state == SEND && idx != 3'd5) ? send_next : 8'hFF;
        r1_val   = (state == WAIT_R1) ? rx_sh : r1;
        data_ok  = read_l && (r1_val == 8'h00);
        after_r1 = data_ok ? TOKEN : TAIL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 3'd0;
            r1         <= 8'hFF;
            resp_word  <= 32'd0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            data_crc   <= 16'd0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= 3'd0;
            idx        <= 3'd0;
            tx_sh      <= 8'hFF;
            rx_sh      <= 8'hFF;
            ncr_cnt    <= 8'd0;
            tok_cnt    <= 16'd0;
            dat_cnt    <= 13'd0;
            arg_l      <= 32'd0;
            crc_l      <= 7'd0;
            ext_l      <= 1'b0;
            read_l     <= 1'b0;
        end else begin
            done       <= 1'b0;
            data_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    arg_l   <= cmd_arg;
                    crc_l   <= cmd_crc;
                    ext_l   <= resp_ext;
                    read_l  <= read_data;
                    tx_sh   <= {2'b01, cmd_index};
                    mosi    <= 1'b0;
                    busy    <= 1'b1;
                    cs_n    <= 1'b0;
                    err     <= 3'd0;
                    idx     <= 3'd0;
                    div_cnt <= '0;
                    bit_cnt <= 3'd0;
                    ncr_cnt <= 8'd0;
                    tok_cnt <= 16'd0;
                    dat_cnt <= 13'd0;
                    state   <= SEND;
                end
            end else if (!half_end) begin
                div_cnt <= div_cnt + DW'(1);
            end else if (!sclk) begin
                div_cnt <= '0;
                sclk    <= 1'b1;
                rx_sh   <= {rx_sh[6:0], miso};
            end else begin
                div_cnt <= '0;
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (!byte_end) begin
                    tx_sh <= {tx_sh[6:0], 1'b1};
                    mosi  <= tx_sh[6];
                end else begin
                    // byte boundary: next byte's MSB goes out on the same falling edge
                    tx_sh <= next_tx;
                    mosi  <= next_tx[7];
                    case (state)
                        SEND: begin
                            if (idx == 3'd5) begin
                                idx   <= 3'd0;
                                state <= WAIT_R1;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                        WAIT_R1: begin
                            if (!rx_sh[7]) begin
                                r1 <= rx_sh;
                                if (ext_l) begin
                                    state <= EXT;
                                end else begin
                                    state <= after_r1;
                                    cs_n  <= !data_ok;
                                    if (read_l && !data_ok) err <= 3'd4;
                                end
                            end else if (ncr_cnt == 8'(NCR_MAX - 1)) begin
                                err   <= 3'd1;
                                cs_n  <= 1'b1;
                                state <= TAIL;
                            end else begin
                                ncr_cnt <= ncr_cnt + 8'd1;
                            end
                        end
                        EXT: begin
                            resp_word <= {resp_word[23:0], rx_sh};
                            if (idx == 3'd3) begin
                                state <= after_r1;
                                cs_n  <= !data_ok;
                                if (read_l && !data_ok) err <= 3'd4;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                        TOKEN: begin
                            if (rx_sh == 8'hFE) begin
                                state <= DATA;
                            end else if (rx_sh[7:4] == 4'h0) begin
                                err   <= 3'd3;
                                cs_n  <= 1'b1;
                                state <= TAIL;
                            end else if (tok_cnt == 16'(TOKEN_MAX - 1)) begin
                                err   <= 3'd2;
                                cs_n  <= 1'b1;
                                state <= TAIL;
                            end else begin
                                tok_cnt <= tok_cnt + 16'd1;
                            end
                        end
                        DATA: begin
                            data_out   <= rx_sh;
                            data_valid <= 1'b1;
                            if (dat_cnt == 13'(DATA_BYTES - 1)) begin
                                idx   <= 3'd0;
                                state <= CRC;
                            end else begin
                                dat_cnt <= dat_cnt + 13'd1;
                            end
                        end
                        CRC: begin
                            data_crc <= {data_crc[7:0], rx_sh};
                            if (idx == 3'd1) begin
                                cs_n  <= 1'b1;
                                state <= TAIL;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                        TAIL: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb/tb_sd_spi_cmd_engine.sv - randomized bench for sd_spi_cmd_engine with a byte-script card model
module tb_sd_spi_cmd_engine;
    localparam int NCR_MAX    = 8;
    localparam int DATA_BYTES = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [6:0]  cmd_crc = 7'd0;
    logic        resp_ext = 1'b0;
    logic        read_data = 1'b0;
    logic        busy, done, data_valid, sclk, cs_n, mosi, miso;
    logic [2:0]  err;
    logic [7:0]  r1, data_out;
    logic [31:0] resp_word;
    logic [15:0] data_crc;

    always #5 clk = ~clk;

    sd_spi_cmd_engine #(.CLK_DIV(2), .NCR_MAX(NCR_MAX), .TOKEN_MAX(4096), .DATA_BYTES(DATA_BYTES)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_crc(cmd_crc), .resp_ext(resp_ext), .read_data(read_data), .busy(busy), .done(done),
        .err(err), .r1(r1), .resp_word(resp_word), .data_out(data_out), .data_valid(data_valid),
        .data_crc(data_crc), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Card: plays cbytes[] out per byte slot while selected, 0xFF beyond the script
    logic [7:0] cbytes [0:1023];
    int         clen = 0;
    int         bitpos = 0;
    int         low_bits = 0;
    logic       mbit [0:8191];
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = 8'hFF;
        if (!cs_n && (bitpos / 8) < clen) cur_byte = cbytes[bitpos / 8];
        miso = cur_byte[3'(7 - (bitpos % 8))];
    end

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            if (bitpos != 0) low_bits <= bitpos;
            bitpos <= 0;
        end else begin
            mbit[bitpos] <= mosi;
            bitpos <= bitpos + 1;
        end
    end

    // Reference model state
    logic [7:0]  exp_r1 = 8'hFF;
    logic [31:0] exp_resp = 32'd0;
    logic [15:0] exp_crc = 16'd0;
    logic [2:0]  exp_err = 3'd0;
    int          exp_low = 0;
    logic [7:0]  exp_q [$];
    int          full_reads = 0;
    int          dv_count = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_count++;
            if (exp_q.size() == 0) begin
                chk("data_extra", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("data", data_out, e);
            end
        end
    end

    task automatic push(input logic [7:0] b);
        cbytes[clen] = b;
        clen++;
    endtask

    task automatic build(input int d, input logic [7:0] r1v, input logic ext, input logic [31:0] extw,
                         input logic rd, input int t, input logic [7:0] tok, input logic rnd,
                         input logic [15:0] crcv);
        logic [7:0] b;
        clen = 0;
        exp_q.delete();
        exp_err = 3'd0;
        repeat (6) push(8'hFF);
        repeat (d) push(8'hFF);
        if (d >= NCR_MAX) begin
            exp_err = 3'd1;
            exp_low = 6 + NCR_MAX;
        end else begin
            push(r1v);
            exp_r1  = r1v;
            exp_low = 6 + d + 1;
            if (ext) begin
                for (int i = 0; i < 4; i++) push(8'(extw >> (24 - 8 * i)));
                exp_resp = extw;
                exp_low += 4;
            end
            if (rd && r1v != 8'h00) begin
                exp_err = 3'd4;
            end else if (rd) begin
                repeat (t) push(8'hFF);
                push(tok);
                exp_low += t + 1;
                if (tok == 8'hFE) begin
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        b = rnd ? 8'($urandom) : 8'(i);
                        push(b);
                        exp_q.push_back(b);
                    end
                    push(crcv[15:8]);
                    push(crcv[7:0]);
                    exp_crc = crcv;
                    exp_low += DATA_BYTES + 2;
                    full_reads++;
                end else begin
                    exp_err = 3'd3;
                end
            end
        end
    endtask

    task automatic run_txn(input logic [5:0] ci, input logic [31:0] ca, input logic [6:0] cc,
                           input logic ext, input logic rd, output logic [47:0] frame);
        int   cyc;
        logic poll_ff;
        @(negedge clk);
        cmd_index = ci; cmd_arg = ca; cmd_crc = cc; resp_ext = ext; read_data = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cs_n_after_start", cs_n, 0);
        cmd_index = 6'($urandom); cmd_arg = $urandom; cmd_crc = 7'($urandom);
        resp_ext = 1'($urandom); read_data = 1'($urandom);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("err", err, exp_err);
        chk("r1", r1, exp_r1);
        chk("resp_word", resp_word, exp_resp);
        chk("data_crc", data_crc, exp_crc);
        chk("cs_low_bits", low_bits, exp_low * 8);
        frame = 48'd0;
        for (int i = 0; i < 48; i++) frame = {frame[46:0], mbit[i]};
        chk("frame", frame, {2'b01, ci, ca, cc, 1'b1});
        poll_ff = 1'b1;
        for (int i = 48; i < exp_low * 8 && i < 8192; i++) if (mbit[i] !== 1'b1) poll_ff = 1'b0;
        chk("mosi_poll_ff", poll_ff, 1);
        chk("data_left", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_pins", {cs_n, sclk, mosi}, 3'b101);
    endtask

    initial begin
        logic [47:0] fr;
        int          dv0;
        int          cyc;
        int          d, t;
        logic [7:0]  r1v, tok;
        logic        ext, rd;

        repeat (3) @(negedge clk);
        chk("rst_busy_done", {busy, done, data_valid}, 3'b000);
        chk("rst_err", err, 0);
        chk("rst_r1", r1, 8'hFF);
        chk("rst_regs", {resp_word, data_crc, data_out}, 56'd0);
        chk("rst_pins", {cs_n, sclk, mosi}, 3'b101);
        reset = 1'b0;

        build(1, 8'h01, 1'b0, 32'd0, 1'b0, 0, 8'hFF, 1'b0, 16'd0);
        run_txn(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0, fr);
        chk("cmd0_frame", fr, 48'h40_00_00_00_00_95);

        build(0, 8'h01, 1'b1, 32'h0000_01AA, 1'b0, 0, 8'hFF, 1'b0, 16'd0);
        run_txn(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b0, fr);
        chk("cmd8_resp", resp_word, 32'h0000_01AA);

        dv0 = dv_count;
        build(0, 8'h00, 1'b0, 32'd0, 1'b1, 3, 8'hFE, 1'b0, 16'h1234);
        run_txn(6'd17, 32'd0, 7'h2A, 1'b0, 1'b1, fr);
        chk("cmd17_strobes", dv_count - dv0, DATA_BYTES);
        chk("cmd17_crc", data_crc, 16'h1234);

        build(20, 8'h00, 1'b0, 32'd0, 1'b0, 0, 8'hFF, 1'b0, 16'd0);
        run_txn(6'd17, 32'h55, 7'h11, 1'b0, 1'b1, fr);
        chk("ncr_timeout_err", err, 1);

        dv0 = dv_count;
        build(0, 8'h00, 1'b0, 32'd0, 1'b1, 1, 8'h08, 1'b0, 16'd0);
        run_txn(6'd17, 32'h200, 7'h3C, 1'b0, 1'b1, fr);
        build(2, 8'h04, 1'b0, 32'd0, 1'b1, 0, 8'hFE, 1'b0, 16'd0);
        run_txn(6'd17, 32'h400, 7'h5A, 1'b0, 1'b1, fr);
        chk("no_strobes_on_errors", dv_count - dv0, 0);

        // Reset in the middle of the payload
        build(0, 8'h00, 1'b0, 32'd0, 1'b1, 2, 8'hFE, 1'b1, 16'hBEEF);
        @(negedge clk);
        cmd_index = 6'd17; cmd_arg = 32'h800; cmd_crc = 7'h01; resp_ext = 1'b0; read_data = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dv0 = dv_count;
        cyc = 0;
        while (dv_count < dv0 + 5 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_data", dv_count >= dv0 + 5, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pins", {cs_n, sclk, busy, done}, 4'b1000);
        chk("midrst_regs", {err, r1, data_crc}, {3'd0, 8'hFF, 16'd0});
        reset = 1'b0;
        exp_q.delete();
        exp_r1 = 8'hFF; exp_resp = 32'd0; exp_crc = 16'd0;
        build(3, 8'h01, 1'b1, 32'hC0FF_8000, 1'b0, 0, 8'hFF, 1'b0, 16'd0);
        run_txn(6'd58, 32'd0, 7'h7E, 1'b1, 1'b0, fr);

        for (int n = 0; n < 14; n++) begin
            d   = $urandom_range(0, 9);
            r1v = ($urandom_range(0, 1) == 0) ? 8'h00 : {1'b0, 7'($urandom)};
            ext = 1'($urandom);
            rd  = 1'($urandom);
            t   = $urandom_range(0, 5);
            tok = (full_reads < 3 && $urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom_range(0, 15));
            build(d, r1v, ext, $urandom, rd, t, tok, 1'b1, 16'($urandom));
            run_txn(6'($urandom), $urandom, 7'($urandom), ext, rd, fr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
